data_mem_responder: RTL

- Memory-side responder for CPU load/store requests, replacing the single-cycle combinational data memory.
- The core issues one request at a time: byte address, write data, store-enable and funct3. The block stores the data into, or loads it from, an internal word array and returns load data after a fixed latency.
- Loads are sign- or zero-extended. Requests that are misaligned, out of range or use an unsupported funct3 return an error.
- Sits between the memory stage and the backing RAM; it is the first step toward a stalling (multi-cycle) memory path.

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/load_align.sv | 42 ++++
 rtl/data_mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_resp_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Access size and sign selection, taken from instr[14:12].
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the wait-state counter (WAIT_CYCLES is 0..15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half from a memory word and sign- or
// zero-extends it according to funct3.
module load_align
    import mem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the little-endian byte lane and half lane addressed by addr_lo.
    always_comb begin
        // NOTE: every signal gets a default at the top of a combinational
        // block so no path leaves it unassigned and no latch is inferred.
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane; unsupported encodings yield zero.
    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = word;
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU loads/stores: accepts one request at a time,
// waits WAIT_CYCLES, performs the access against an internal word array and
// holds the response until the consumer takes it.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int               DEPTH     = 1 << (ADDR_WIDTH - 2);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    // Control state and latched request.
    state_e                  state_q,      state_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic [31:0]             addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,      wdata_d;
    logic                    we_q,         we_d;
    logic [2:0]              funct3_q,     funct3_d;

    // Registered outputs.
    logic                    req_ready_q,  req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q,   resp_err_d;

    // Access datapath.
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   load_data;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wdata_lane;
    logic                    f3_err;
    logic                    align_err;
    logic                    range_err;
    logic                    acc_err;
    logic                    mem_we;

    assign word_idx = addr_q[ADDR_WIDTH-1:2];
    assign rd_word  = mem[word_idx];

    load_align u_load_align (
        .word    (rd_word),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    // Reject misaligned, out-of-range and unsupported accesses.
    always_comb begin
        f3_err    = 1'b0;
        align_err = 1'b0;
        case (funct3_q)
            F3_B:  ;
            F3_H:  align_err = addr_q[0];
            F3_W:  align_err = |addr_q[1:0];
            F3_BU: f3_err    = we_q;
            F3_HU: begin
                f3_err    = we_q;
                align_err = addr_q[0];
            end
            default: f3_err = 1'b1;
        endcase
    end

    assign range_err = |addr_q[31:ADDR_WIDTH];
    assign acc_err   = f3_err | align_err | range_err;

    // Byte enables and lane-replicated store data for SB/SH/SW.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = wdata_q;
        case (funct3_q)
            F3_B: begin
                be         = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    we_d        = req_we;
                    funct3_d    = req_funct3;
                    cnt_d       = WAIT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // The store commits on this edge; a rejected access writes nothing.
                    mem_we       = we_q & ~acc_err;
                    resp_rdata_d = (we_q | acc_err) ? '0 : load_data;
                    resp_err_d   = acc_err;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset drops any pending access.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-masked write into the storage array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto plain RAM; writes are
        // gated by the FSM, which reset forces out of WAIT.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
